// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Phase sequencer for a two-road intersection (NS main road, EW side road).
// State and timers advance only on clock edges where the 100 ms tick is high.
// Side-road vehicle and pedestrian requests are latched. A flashing mode is
// entered for night or fault operation.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   tick      one-clock pulse every 100 ms
//   ew_req    side-road vehicle sensor (level)
//   ped_req   pedestrian button (pulse or level)
//   flash_en  flashing-mode request (level)
//   ns_light  NS head {R,Y,G}; 000 during the flash off-phase
//   ew_light  EW head {R,Y,G}; 000 during the flash off-phase
//   ped_walk  walk lamp for crossing NS
//   remain    ticks left in the current phase
//   phase     current state code
module traffic_phase_ctrl #(
  parameter int unsigned CW         = 10,
  parameter int unsigned T_NS_MIN   = 300,
  parameter int unsigned T_EW_GREEN = 200,
  parameter int unsigned T_YELLOW   = 30,
  parameter int unsigned T_ALLRED   = 10,
  parameter int unsigned T_WALK     = 100,
  parameter int unsigned T_FLASH    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          ew_req,
  input  logic          ped_req,
  input  logic          flash_en,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          ped_walk,
  output logic [CW-1:0] remain,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StAllRed1  = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StAllRed2  = 3'd5,
    StFlash    = 3'd6
  } state_e;

  // Last elapsed value of each timed state (state of length T exits at T-1).
  localparam logic [CW-1:0] NsMinLast   = CW'(T_NS_MIN - 1);
  localparam logic [CW-1:0] EwGreenLast = CW'(T_EW_GREEN - 1);
  localparam logic [CW-1:0] YellowLast  = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AllRedLast  = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] FlashLast   = CW'(T_FLASH - 1);
  localparam logic [CW-1:0] WalkLen     = CW'(T_WALK);

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampOff    = 3'b000;

  state_e        state_q, state_d;
  logic [CW-1:0] elapsed_q, elapsed_d;
  logic          ew_pend_q, ew_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ped_served_q, ped_served_d;
  logic          lit_q, lit_d;

  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;
  logic          walk_q, walk_d;
  logic [CW-1:0] remain_q, remain_d;
  logic [2:0]    phase_q;

  // Next state, phase timer and flash blink.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    lit_d     = lit_q;
    if (tick) begin
      elapsed_d = elapsed_q + 1'b1;
      case (state_q)
        StNsGreen: begin
          if (flash_en || ((elapsed_q >= NsMinLast) && (ew_pend_q || ped_pend_q))) begin
            state_d = StNsYellow;
          end else if (elapsed_q >= NsMinLast) begin
            elapsed_d = NsMinLast;  // rest with the timer saturated
          end
        end
        StNsYellow: if (elapsed_q == YellowLast) state_d = StAllRed1;
        StAllRed1:  if (elapsed_q == AllRedLast) state_d = flash_en ? StFlash : StEwGreen;
        StEwGreen:  if (flash_en || (elapsed_q == EwGreenLast)) state_d = StEwYellow;
        StEwYellow: if (elapsed_q == YellowLast) state_d = StAllRed2;
        StAllRed2:  if (elapsed_q == AllRedLast) state_d = flash_en ? StFlash : StNsGreen;
        StFlash: begin
          if (!flash_en) begin
            state_d = StAllRed2;
          end else if (elapsed_q == FlashLast) begin
            // In FLASH the timer counts the half-period instead of the phase.
            elapsed_d = '0;
            lit_d     = ~lit_q;
          end
        end
        default: state_d = StAllRed2;
      endcase
      if (state_d != state_q) begin
        elapsed_d = '0;
        lit_d     = 1'b1;
      end
    end
  end

  // Request latches; requests arriving while EW is green are dropped.
  always_comb begin
    ew_pend_d    = ew_pend_q  | (ew_req  && (state_q != StEwGreen));
    ped_pend_d   = ped_pend_q | (ped_req && (state_q != StEwGreen));
    ped_served_d = ped_served_q;
    if ((state_d == StEwGreen) && (state_q != StEwGreen)) begin
      ew_pend_d    = 1'b0;
      ped_pend_d   = 1'b0;
      ped_served_d = ped_pend_q;
    end
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    ns_d     = LampRed;
    ew_d     = LampRed;
    remain_d = '0;
    walk_d   = (state_d == StEwGreen) && ped_served_d && (elapsed_d < WalkLen);
    case (state_d)
      StNsGreen: begin
        ns_d     = LampGreen;
        remain_d = NsMinLast - elapsed_d;
      end
      StNsYellow: begin
        ns_d     = LampYellow;
        remain_d = YellowLast - elapsed_d;
      end
      StEwGreen: begin
        ew_d     = LampGreen;
        remain_d = EwGreenLast - elapsed_d;
      end
      StEwYellow: begin
        ew_d     = LampYellow;
        remain_d = YellowLast - elapsed_d;
      end
      StFlash: begin
        ns_d     = lit_d ? LampYellow : LampOff;
        ew_d     = lit_d ? LampRed : LampOff;
        remain_d = '0;
      end
      default: remain_d = AllRedLast - elapsed_d;  // both all-red phases
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAllRed2;
      elapsed_q    <= '0;
      ew_pend_q    <= 1'b0;
      ped_pend_q   <= 1'b0;
      ped_served_q <= 1'b0;
      lit_q        <= 1'b1;
      ns_q         <= LampRed;
      ew_q         <= LampRed;
      walk_q       <= 1'b0;
      remain_q     <= AllRedLast;
      phase_q      <= StAllRed2;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      ew_pend_q    <= ew_pend_d;
      ped_pend_q   <= ped_pend_d;
      ped_served_q <= ped_served_d;
      lit_q        <= lit_d;
      ns_q         <= ns_d;
      ew_q         <= ew_d;
      walk_q       <= walk_d;
      remain_q     <= remain_d;
      phase_q      <= state_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign ped_walk = walk_q;
  assign remain   = remain_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a tick-level reference model pushes the
// expected outputs for every clock into a queue; a monitor pops and compares.
module tb_traffic_phase_ctrl;

  localparam int CW         = 10;
  localparam int T_NS_MIN   = 300;
  localparam int T_EW_GREEN = 200;
  localparam int T_YELLOW   = 30;
  localparam int T_ALLRED   = 10;
  localparam int T_WALK     = 100;
  localparam int T_FLASH    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          ew_req = 1'b0;
  logic          ped_req = 1'b0;
  logic          flash_en = 1'b0;
  logic [2:0]    ns_light, ew_light;
  logic          ped_walk;
  logic [CW-1:0] remain;
  logic [2:0]    phase;

  traffic_phase_ctrl #(
    .CW(CW), .T_NS_MIN(T_NS_MIN), .T_EW_GREEN(T_EW_GREEN), .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED), .T_WALK(T_WALK), .T_FLASH(T_FLASH)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ew_req(ew_req), .ped_req(ped_req),
    .flash_en(flash_en), .ns_light(ns_light), .ew_light(ew_light),
    .ped_walk(ped_walk), .remain(remain), .phase(phase)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0]    ns;
    logic [2:0]    ew;
    logic          walk;
    logic [CW-1:0] remain;
    logic [2:0]    phase;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   timeout_hit = 0;
  bit   timeout_seen = 0;

  // Reference model: phase number plus an unbounded count of ticks spent in it.
  int m_phase = 5;
  int m_t = 0;
  bit m_ewp = 0, m_pp = 0, m_served = 0;

  function automatic int dur(input int p);
    case (p)
      0:       return T_NS_MIN;
      1, 4:    return T_YELLOW;
      3:       return T_EW_GREEN;
      2, 5:    return T_ALLRED;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t expect_now(input int p, input int t, input bit served);
    exp_t e;
    int   r;
    e.phase = 3'(p);
    e.ns = 3'b100;
    e.ew = 3'b100;
    case (p)
      0: e.ns = 3'b001;
      1: e.ns = 3'b010;
      3: e.ew = 3'b001;
      4: e.ew = 3'b010;
      6: begin
        e.ns = ((t / T_FLASH) % 2 == 0) ? 3'b010 : 3'b000;
        e.ew = ((t / T_FLASH) % 2 == 0) ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
    r = dur(p) - 1 - t;
    if (r < 0 || p == 6) r = 0;
    e.remain = CW'(r);
    e.walk = (p == 3) && served && (t < T_WALK);
    return e;
  endfunction

  always @(posedge clk) begin
    int prev, nxt;
    bit old_pp;
    if (rst) begin
      m_phase = 5; m_t = 0; m_ewp = 0; m_pp = 0; m_served = 0;
    end else begin
      prev = m_phase;
      nxt = m_phase;
      old_pp = m_pp;
      if (tick) begin
        case (prev)
          0: if (flash_en || (m_t >= T_NS_MIN - 1 && (m_ewp || m_pp))) nxt = 1;
          1: if (m_t + 1 == T_YELLOW) nxt = 2;
          2: if (m_t + 1 == T_ALLRED) nxt = flash_en ? 6 : 3;
          3: if (flash_en || m_t + 1 == T_EW_GREEN) nxt = 4;
          4: if (m_t + 1 == T_YELLOW) nxt = 5;
          5: if (m_t + 1 == T_ALLRED) nxt = flash_en ? 6 : 0;
          default: if (!flash_en) nxt = 5;
        endcase
        if (nxt != prev) m_t = 0;
        else m_t++;
        m_phase = nxt;
      end
      if (prev != 3) begin
        m_ewp = m_ewp | ew_req;
        m_pp = m_pp | ped_req;
      end
      if (m_phase == 3 && prev != 3) begin
        m_served = old_pp;
        m_ewp = 0;
        m_pp = 0;
      end
    end
    exp_q.push_back(expect_now(m_phase, m_t, m_served));
  end

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{ns: ns_light, ew: ew_light, walk: ped_walk, remain: remain, phase: phase};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got ns=%b ew=%b walk=%b remain=%0d phase=%0d want ns=%b ew=%b walk=%b remain=%0d phase=%0d",
                 $time, a.ns, a.ew, a.walk, a.remain, a.phase,
                 e.ns, e.ew, e.walk, e.remain, e.phase);
      end
    end
    if (timeout_hit && !timeout_seen) begin
      timeout_seen = 1;
      checks++;
      errors++;
      $display("FAIL phase_wait got timeout want phase reached within budget");
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic wait_phase(input int p, input int limit);
    int n = 0;
    while (m_phase != p && n < limit) begin
      ticks(1);
      n++;
    end
    if (m_phase != p) timeout_hit = 1;
  endtask

  task automatic pulse_ew();
    ew_req = 1'b1; cyc(); ew_req = 1'b0;
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    // Reset with tick high: tick must be ignored.
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    rst = 1'b0;

    // Idle: all-red then NS green resting with remain saturated at 0.
    ticks(1400);

    // Vehicle request early in NS green.
    pulse_rst();
    ticks(10 + 50);
    pulse_ew();
    wait_phase(3, 400);
    wait_phase(0, 400);
    ticks(20);

    // Pedestrian request after min green: yellow next tick, walk lamp served.
    ticks(400);
    pulse_ped();
    wait_phase(3, 100);
    wait_phase(0, 400);

    // Flash request during EW green, then release.
    pulse_ew();
    wait_phase(3, 400);
    ticks(20);
    flash_en = 1'b1;
    ticks(80);
    flash_en = 1'b0;
    wait_phase(0, 50);
    ticks(5);

    // Vehicle sensor active only during EW green is not latched.
    pulse_ped();
    wait_phase(3, 400);
    ew_req = 1'b1;
    ticks(50);
    ew_req = 1'b0;
    wait_phase(0, 400);
    ticks(800);

    // Reset in the middle of EW green.
    pulse_ew();
    wait_phase(3, 400);
    ticks(120);
    ew_req = 1'b1;
    pulse_rst();
    ew_req = 1'b0;
    ticks(400);

    // Random traffic.
    repeat (24000) begin
      tick     = ($urandom_range(0, 2) == 0);
      ew_req   = ($urandom_range(0, 299) == 0);
      ped_req  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1999) == 0) flash_en = ~flash_en;
      rst      = ($urandom_range(0, 7999) == 0);
      cyc();
    end
    tick = 1'b0; ew_req = 1'b0; ped_req = 1'b0; flash_en = 1'b0; rst = 1'b0;

    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
